rotador_secuencial: RTL and testbench
=====================================

Name: rotador_secuencial

Overview:
Sequential rotate stage built around the 2-bit rotation step used elsewhere in the datapath. It loads an ANCHO-bit word on a start pulse and applies the rotation repeatedly, one step per clock, for a requested number of steps. It then presents the result with a one-cycle done pulse. It sits directly upstream of consumers of rotated bytes and replaces chains of combinational rotators with one registered stage.

Parameters:
ANCHO, 8, data width in bits; must be even and >= 4.
ANCHO_PASOS, 3, width of the step-count input; maximum request is 2^ANCHO_PASOS-1 steps.

Ports:
Reloj  input  1  single system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Inicio  input  1  start request, sampled on rising edge of Reloj.
Dato  input  ANCHO  word to rotate, captured when a start is accepted.
Pasos  input  ANCHO_PASOS  number of 2-bit rotation steps, captured with Dato.
Ocupado  output  1  high while an operation is in progress (states ROTANDO and LISTO).
Listo  output  1  one-cycle pulse; Resultado is valid in this cycle.
Resultado  output  ANCHO  working register; final value holds after completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are Reloj and Reset_n. All outputs are registered and there are no combinational paths from inputs to outputs.
- Rotation step, exact bit mapping: next = {cur[1:0], cur[ANCHO-1:2]}. For 8 bits: next[7:6] = cur[1:0] and next[5:0] = cur[7:2].
- State machine states: REPOSO, ROTANDO, LISTO.
- REPOSO:
  - If Inicio=1, load reg <= Dato and cnt <= Pasos.
  - Next state is ROTANDO if Pasos != 0, otherwise LISTO.
  - If Inicio=0, stay in REPOSO; reg holds its value.
- ROTANDO:
  - Each cycle: reg <= rot(reg), cnt <= cnt-1.
  - When cnt == 1 in this cycle, next state is LISTO.
  - Exactly Pasos rotations are applied.
- LISTO:
  - Listo=1 for exactly this cycle.
  - Next state is REPOSO unconditionally.
- Latency: with the start accepted at edge t, Listo is high in the cycle following edge t+Pasos.
  - Pasos=0: Listo high in the cycle after edge t, Resultado = Dato.
- Ocupado is 1 in ROTANDO and LISTO, and 0 in REPOSO. A new start can be accepted in the first REPOSO cycle after LISTO.
- Inicio during ROTANDO or LISTO is ignored, with no queuing. Dato and Pasos are don't-care outside the accepting edge.
- Inicio held high continuously: a new operation starts on every edge where the state is REPOSO (back-to-back operations separated by the LISTO cycle).
- Resultado changes during ROTANDO. Consumers must sample it only when Listo=1. After completion it holds the final value in REPOSO until the next accepted start.
- Periodicity: rotating ANCHO/2 steps returns the original word. This must emerge naturally; no modulo reduction of Pasos is permitted.
- Reset (asynchronous assertion, at any time including mid-operation):
  - State goes to REPOSO; reg, cnt, Listo and Ocupado are cleared to 0.
  - Resultado reads 0 while reset is asserted and afterwards until the next load.
  - Any partial operation is discarded.
- Reset deassertion is synchronised by the system. The first start may be accepted on the first edge after Reset_n rises.

Test Plan:
- Reset values: assert Reset_n=0 mid-cycle -> Resultado=8'h00, Listo=0, Ocupado=0 immediately, without waiting for a clock edge.
- Single step: Dato=8'hB4, Pasos=1, pulse Inicio -> Listo high 2 cycles after the start edge, Resultado=8'h2D, Ocupado high for 2 cycles.
- Multi-step and wrap: Dato=8'hB4 with Pasos=2, 3, 4, 5, 7 -> Resultado 8'h4B, 8'hD2, 8'hB4, 8'h2D, 8'hD2 respectively; Listo latency Pasos+1 cycles.
- Zero steps: Dato=8'h5A, Pasos=0 -> Listo one cycle after the start edge, Resultado=8'h5A.
- Ignored start: Dato=8'hB4, Pasos=3; re-pulse Inicio with Dato=8'hFF while Ocupado=1 -> result stays 8'hD2, exactly one Listo pulse. Then Inicio held high -> back-to-back operations, Listo every Pasos+2 cycles.
- Reset mid-operation: Pasos=7, deassert Reset_n after 3 rotating cycles -> outputs cleared, no Listo pulse. After release, a new start with Dato=8'h01, Pasos=1 -> Resultado=8'h40.

Source files
------------

// File: rtl/rotador_secuencial.sv
// Sequential rotate stage: loads a word on Inicio and rotates it right by 2 bits
// once per clock for Pasos steps, then flags the result with a one-cycle Listo.
module rotador_secuencial #(
  parameter int ANCHO       = 8,
  parameter int ANCHO_PASOS = 3
) (
  input  logic                   Reloj,
  input  logic                   Reset_n,
  input  logic                   Inicio,
  input  logic [ANCHO-1:0]       Dato,
  input  logic [ANCHO_PASOS-1:0] Pasos,
  output logic                   Ocupado,
  output logic                   Listo,
  output logic [ANCHO-1:0]       Resultado,
  output logic [1:0]             Estado
);

  // Handshake: Inicio acts as valid and ~Ocupado as ready. A start is taken
  // only on an edge where the machine is in REPOSO; Inicio at any other time
  // is dropped, never queued. Dato/Pasos matter only on that accepting edge.

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ROTANDO = 2'd1,
    LISTO   = 2'd2
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [ANCHO-1:0]       reg_q, reg_d;
  logic [ANCHO_PASOS-1:0] cnt_q, cnt_d;
  logic                   listo_q, ocupado_q;

  function automatic logic [ANCHO-1:0] rot2(input logic [ANCHO-1:0] v);
    return {v[1:0], v[ANCHO-1:2]};
  endfunction

  always_comb begin
    estado_d = estado_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    case (estado_q)
      REPOSO: begin
        if (Inicio) begin
          reg_d    = Dato;
          cnt_d    = Pasos;
          estado_d = (Pasos != '0) ? ROTANDO : LISTO;
        end
      end
      ROTANDO: begin
        reg_d = rot2(reg_q);
        cnt_d = cnt_q - ANCHO_PASOS'(1);
        if (cnt_q == ANCHO_PASOS'(1)) estado_d = LISTO;
      end
      LISTO:   estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Listo/Ocupado are decoded from the next state so they leave a flop directly.
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q  <= REPOSO;
      reg_q     <= '0;
      cnt_q     <= '0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      reg_q     <= reg_d;
      cnt_q     <= cnt_d;
      listo_q   <= (estado_d == LISTO);
      ocupado_q <= (estado_d != REPOSO);
    end
  end

  assign Resultado = reg_q;
  assign Listo     = listo_q;
  assign Ocupado   = ocupado_q;
  assign Estado    = estado_q;

endmodule

// File: tb/tb_rotador_secuencial.sv
// Bench for rotador_secuencial: timing-level reference model plus a result
// scoreboard, with directed cases followed by randomized traffic.
module tb_rotador_secuencial;

  localparam int W = 8;

  logic         Reloj = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Inicio = 1'b0;
  logic [W-1:0] Dato = '0;
  logic [2:0]   Pasos = '0;
  logic         Ocupado, Listo;
  logic [W-1:0] Resultado;
  logic [1:0]   Estado;

  int n_checks = 0;
  int n_fail   = 0;

  rotador_secuencial #(.ANCHO(W), .ANCHO_PASOS(3)) dut (
    .Reloj(Reloj), .Reset_n(Reset_n), .Inicio(Inicio), .Dato(Dato),
    .Pasos(Pasos), .Ocupado(Ocupado), .Listo(Listo), .Resultado(Resultado),
    .Estado(Estado)
  );

  // ---------------- clock / reset ----------------
  always #5 Reloj = ~Reloj;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word rotated right by 2*k bits (rotation by W/2 steps is the identity).
  function automatic logic [W-1:0] rotm(input logic [W-1:0] v, input int k);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] sh;
    dd = {v, v};
    sh = dd >> (2 * (k % (W / 2)));
    return sh[W-1:0];
  endfunction

  // ---------------- reference model ----------------
  // An accepted start at edge t with p steps keeps the unit busy through the
  // cycle after edge t+p, during which Listo is high; the next start can be
  // taken at edge t+p+2. After edge t+k the working value is the word
  // rotated k times.
  int           cyc = 0;
  bit           have_op = 0;
  int           op_start = 0;
  int           op_p = 0;
  logic [W-1:0] op_d = '0;
  logic         exp_listo = 1'b0;
  logic         exp_ocup = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge Reloj) begin
    if (Reset_n) begin
      cyc++;
      if (Inicio && (!have_op || cyc >= op_start + op_p + 2)) begin
        have_op  = 1;
        op_start = cyc;
        op_p     = int'(Pasos);
        op_d     = Dato;
        exp_q.push_back(rotm(Dato, int'(Pasos)));
      end
      if (have_op && cyc <= op_start + op_p) begin
        exp_res   = rotm(op_d, cyc - op_start);
        exp_ocup  = 1'b1;
        exp_listo = (cyc == op_start + op_p);
      end else begin
        exp_ocup  = 1'b0;
        exp_listo = 1'b0;
        exp_res   = have_op ? rotm(op_d, op_p) : '0;
      end
    end
  end

  always @(negedge Reset_n) begin
    have_op   = 0;
    exp_listo = 1'b0;
    exp_ocup  = 1'b0;
    exp_res   = '0;
    exp_q.delete();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Reloj) begin
    chk("cyc_listo", Listo, exp_listo);
    chk("cyc_ocupado", Ocupado, exp_ocup);
    chk("cyc_resultado", Resultado, exp_res);
    if (Listo === 1'b1) begin
      chk("sb_listo_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_result", Resultado, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge Reloj);
    #1;
  endtask

  // Issues one start from idle and checks latency (edges after the start edge)
  // and the final value against a literal.
  task automatic run_op(input logic [W-1:0] d, input int p, input logic [W-1:0] res,
                        input string name);
    int lat;
    @(posedge Reloj); #1;
    Inicio = 1'b1; Dato = d; Pasos = 3'(p);
    @(posedge Reloj); #1;
    Inicio = 1'b0; Dato = W'($urandom); Pasos = 3'($urandom);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge Reloj);
      if (Listo) begin lat = i; break; end
      @(posedge Reloj); #1;
    end
    chk({name, "_latency"}, lat, p);
    chk({name, "_result"}, Resultado, res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, first_i, second_i;
    logic [W-1:0] seen;

    // Reset values and immediate clear on asynchronous assertion.
    #23;
    Reset_n = 1'b1;
    idle(2);
    #3 Reset_n = 1'b0;
    #1;
    chk("reset_resultado", Resultado, 8'h00);
    chk("reset_listo", Listo, 0);
    chk("reset_ocupado", Ocupado, 0);
    idle(1);
    Reset_n = 1'b1;
    idle(1);

    // Single step, multi-step and wrap, zero steps.
    run_op(8'hB4, 1, 8'h2D, "step1");
    run_op(8'hB4, 2, 8'h4B, "step2");
    run_op(8'hB4, 3, 8'hD2, "step3");
    run_op(8'hB4, 4, 8'hB4, "step4");
    run_op(8'hB4, 5, 8'h2D, "step5");
    run_op(8'hB4, 7, 8'hD2, "step7");
    run_op(8'h5A, 0, 8'h5A, "step0");
    idle(2);
    chk("hold_after_done", Resultado, 8'h5A);

    // Start while busy is ignored.
    @(posedge Reloj); #1;
    Inicio = 1'b1; Dato = 8'hB4; Pasos = 3'd3;
    @(posedge Reloj); #1;
    Inicio = 1'b0;
    @(posedge Reloj); #1;
    Inicio = 1'b1; Dato = 8'hFF; Pasos = 3'd7;
    @(posedge Reloj); #1;
    Inicio = 1'b0;
    pulses = 0; seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Reloj);
      if (Listo) begin pulses++; seen = Resultado; end
    end
    chk("ignored_pulses", pulses, 1);
    chk("ignored_result", seen, 8'hD2);
    idle(3);

    // Inicio held high: back-to-back operations every Pasos+2 cycles.
    @(posedge Reloj); #1;
    Inicio = 1'b1; Dato = 8'hB4; Pasos = 3'd2;
    @(posedge Reloj);
    pulses = 0; first_i = -1; second_i = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge Reloj);
      if (Listo) begin
        pulses++;
        if (first_i < 0) first_i = i;
        else if (second_i < 0) second_i = i;
        chk("held_result", Resultado, 8'h4B);
      end
    end
    Inicio = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_first", first_i, 2);
    chk("held_period", second_i - first_i, 4);
    idle(8);

    // Reset in the middle of an operation.
    @(posedge Reloj); #1;
    Inicio = 1'b1; Dato = 8'hB4; Pasos = 3'd7;
    @(posedge Reloj); #1;
    Inicio = 1'b0;
    repeat (3) @(posedge Reloj);
    #3 Reset_n = 1'b0;
    #1;
    chk("midreset_resultado", Resultado, 8'h00);
    chk("midreset_listo", Listo, 0);
    chk("midreset_ocupado", Ocupado, 0);
    idle(2);
    Reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Reloj);
      if (Listo) pulses++;
    end
    chk("midreset_no_listo", pulses, 0);
    run_op(8'h01, 1, 8'h40, "after_reset");

    // Randomized traffic, including Inicio while busy and one mid-run reset.
    for (int c = 0; c < 400; c++) begin
      @(posedge Reloj); #1;
      Inicio = ($urandom_range(0, 2) == 0);
      Dato   = W'($urandom);
      Pasos  = 3'($urandom_range(0, 7));
      if (c == 200) begin
        #2 Reset_n = 1'b0;
        #3 Reset_n = 1'b1;
      end
    end
    Inicio = 1'b0;
    idle(12);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
